// File: rtl/alu_exec_pipe.sv
// Two-stage elastic ALU execute unit. S1 holds the accepted operation and
// operands; S2 holds the registered result, zero and illegal flags, which drive
// the out_* ports directly. Full throughput with backpressure.
module alu_exec_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_srca,
  input  logic [WIDTH-1:0] in_srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpSlt = 3'b101;

  logic             s1_valid_q;
  logic [2:0]       s1_ctrl_q;
  logic [WIDTH-1:0] s1_srca_q;
  logic [WIDTH-1:0] s1_srcb_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_zero_q;
  logic             s2_illegal_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  logic s2_adv;
  logic in_hs;
  logic out_hs;

  // Handshake control; in_ready depends only on pipeline state and out_ready.
  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    in_ready = !s1_valid_q | s2_adv;
    in_hs    = in_valid & in_ready;
    out_hs   = s2_valid_q & out_ready;
  end

  logic             do_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic             alu_zero;

  // ALU on S1 contents; add/sub/slt share one adder, slt uses sign ^ overflow.
  always_comb begin
    do_sub      = (s1_ctrl_q == OpSub) || (s1_ctrl_q == OpSlt);
    b_op        = do_sub ? ~s1_srcb_q : s1_srcb_q;
    sum         = s1_srca_q + b_op + WIDTH'(do_sub);
    ovf         = (s1_srca_q[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != s1_srca_q[WIDTH-1]);
    lt          = sum[WIDTH-1] ^ ovf;
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (s1_ctrl_q)
      OpAdd:   alu_result = sum;
      OpSub:   alu_result = sum;
      OpAnd:   alu_result = s1_srca_q & s1_srcb_q;
      OpOr:    alu_result = s1_srca_q | s1_srcb_q;
      OpSlt:   alu_result = {{(WIDTH-1){1'b0}}, lt};
      default: alu_illegal = 1'b1;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Stage 1: capture the operation on an input handshake, empty when it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_srca_q  <= '0;
      s1_srcb_q  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (in_hs) begin
        s1_ctrl_q <= in_ctrl;
        s1_srca_q <= in_srca;
        s1_srcb_q <= in_srcb;
      end
    end
  end

  // Stage 2: data only loads from a valid S1 so outputs hold while out_valid=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_zero_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q  <= alu_result;
        s2_zero_q    <= alu_zero;
        s2_illegal_q <= alu_illegal;
      end
    end
  end

  // Saturating count of illegal ops actually delivered downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt_q <= '0;
    end else if (out_hs && s2_illegal_q && (illegal_cnt_q != '1)) begin
      illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_zero    = s2_zero_q;
  assign out_illegal = s2_illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed and randomised checks of alu_exec_pipe. A second instance with a
// 2-bit counter shares all inputs to exercise counter saturation.
module tb_alu_exec_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_srca;
  logic [31:0] in_srcb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_result2;
  logic        out_zero2;
  logic        out_illegal2;
  logic [1:0]  illegal_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_srca     (in_srca),
    .in_srcb     (in_srcb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  alu_exec_pipe #(.WIDTH(32), .CNT_W(2)) dut_c2 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready2),
    .in_ctrl     (in_ctrl),
    .in_srca     (in_srca),
    .in_srcb     (in_srcb),
    .out_valid   (out_valid2),
    .out_ready   (out_ready),
    .out_result  (out_result2),
    .out_zero    (out_zero2),
    .out_illegal (out_illegal2),
    .illegal_cnt (illegal_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Directed vector table for streaming tests.
  logic [2:0]  v_ctrl[8];
  logic [31:0] v_a[8];
  logic [31:0] v_b[8];
  logic [31:0] v_res[8];
  logic        v_zero[8];
  logic        v_ill[8];

  task automatic set_vec(input int i, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic ill);
    v_ctrl[i] = c;
    v_a[i]    = a;
    v_b[i]    = b;
    v_res[i]  = res;
    v_zero[i] = z;
    v_ill[i]  = ill;
  endtask

  // Back-to-back issue with out_ready=1; op k is visible after edge k+1.
  task automatic stream(input string tag, input int n);
    out_ready = 1'b1;
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) begin
        in_valid = 1'b1;
        in_ctrl  = v_ctrl[k];
        in_srca  = v_a[k];
        in_srcb  = v_b[k];
      end else begin
        in_valid = 1'b0;
      end
      if (k < n) check($sformatf("%s in_ready %0d", tag, k), 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (k >= 1 && k <= n) begin
        check($sformatf("%s valid %0d", tag, k - 1), 32'(out_valid), 32'd1);
        check($sformatf("%s result %0d", tag, k - 1), out_result, v_res[k-1]);
        check($sformatf("%s zero %0d", tag, k - 1), 32'(out_zero), 32'(v_zero[k-1]));
        check($sformatf("%s illegal %0d", tag, k - 1), 32'(out_illegal), 32'(v_ill[k-1]));
      end else begin
        check($sformatf("%s idle valid %0d", tag, k), 32'(out_valid), 32'd0);
      end
    end
  endtask

  // Reference ALU: {illegal, result}.
  function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      3'b000:  model = {1'b0, a + b};
      3'b001:  model = {1'b0, a - b};
      3'b010:  model = {1'b0, a & b};
      3'b011:  model = {1'b0, a | b};
      3'b101:  model = {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      default: model = {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       pick_operand = 32'h0000_0000;
      1:       pick_operand = 32'h8000_0000;
      2:       pick_operand = 32'h7FFF_FFFF;
      3:       pick_operand = 32'hFFFF_FFFF;
      default: pick_operand = $urandom();
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [32:0] exp_q[$];
  logic [32:0] e;
  logic [31:0] got[4];
  logic [31:0] bp_exp[4];
  int          j;
  int          r;
  int          issued;
  int          cyc;
  int          exp_cnt;
  logic        acc;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = 3'b000;
    in_srca   = 32'd0;
    in_srcb   = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_result", out_result, 32'd0);
    check("rst out_zero", 32'(out_zero), 32'd0);
    check("rst out_illegal", 32'(out_illegal), 32'd0);
    check("rst illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst illegal_cnt2", 32'(illegal_cnt2), 32'd0);

    // Basic stream.
    set_vec(0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    set_vec(1, 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    set_vec(2, 3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0);
    set_vec(3, 3'b011, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, 1'b0);
    set_vec(4, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    stream("basic", 5);

    // Overflow and sign edges.
    set_vec(0, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    set_vec(1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    set_vec(2, 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    set_vec(3, 3'b001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    stream("edge", 4);

    // Illegal codes.
    set_vec(0, 3'b100, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b1);
    set_vec(1, 3'b110, 32'hFFFF, 32'h0001, 32'd0, 1'b1, 1'b1);
    set_vec(2, 3'b111, 32'hAAAA, 32'h5555, 32'd0, 1'b1, 1'b1);
    stream("illegal", 3);
    check("illegal_cnt 3", 32'(illegal_cnt), 32'd3);
    check("illegal_cnt2 3", 32'(illegal_cnt2), 32'd3);
    stream("illegal2", 2);
    check("illegal_cnt 5", 32'(illegal_cnt), 32'd5);
    check("illegal_cnt2 sat", 32'(illegal_cnt2), 32'd3);

    // Backpressure: only two ops fit while the output is stalled.
    set_vec(0, 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    set_vec(1, 3'b001, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0);
    set_vec(2, 3'b010, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
    set_vec(3, 3'b011, 32'h100, 32'h1, 32'h101, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bp_exp[i] = v_res[i];
    out_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (j < 4);
      if (j < 4) begin
        in_ctrl = v_ctrl[j];
        in_srca = v_a[j];
        in_srcb = v_b[j];
      end
      #1;
      acc = in_valid & in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) j++;
    end
    check("bp accepted", 32'(j), 32'd2);
    for (int c = 0; c < 10; c++) begin
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_result", out_result, 32'd2);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    r = 0;
    for (int c = 0; c < 20 && r < 4; c++) begin
      in_valid = (j < 4);
      if (j < 4) begin
        in_ctrl = v_ctrl[j];
        in_srca = v_a[j];
        in_srcb = v_b[j];
      end
      #1;
      acc = in_valid & in_ready;
      if (out_valid) begin
        got[r] = out_result;
        r++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) j++;
    end
    in_valid = 1'b0;
    check("bp delivered", 32'(r), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("bp order %0d", i), got[i], bp_exp[i]);
    check("bp no dup", 32'(out_valid), 32'd0);

    // Random ops with random backpressure against a reference queue.
    exp_cnt = 5;
    issued  = 0;
    cyc     = 0;
    while ((issued < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (issued < 1000) && ($urandom_range(0, 3) != 0);
      in_ctrl   = 3'($urandom_range(0, 7));
      in_srca   = pick_operand();
      in_srcb   = pick_operand();
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand unexpected output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand result", out_result, e[31:0]);
          check("rand zero", 32'(out_zero), 32'(e[31:0] == 32'd0));
          check("rand illegal", 32'(out_illegal), 32'(e[32]));
          if (e[32]) exp_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_ctrl, in_srca, in_srcb));
        issued++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("rand issued", 32'(issued), 32'd1000);
    check("rand drained", 32'(exp_q.size()), 32'd0);
    check("rand illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
    check("rand illegal_cnt2", 32'(illegal_cnt2), 32'd3);

    // Reset with both stages full.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 3'b100;
      in_srca  = 32'd3;
      in_srcb  = 32'd4;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full out_valid", 32'(out_valid), 32'd1);
    check("full in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("midrst illegal_cnt2", 32'(illegal_cnt2), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst no stale", 32'(out_valid), 32'd0);
    end
    check("midrst cnt stays 0", 32'(illegal_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
